// File: rtl/wb_spi_pkg.sv
// Shared types and constants for the Wishbone SPI target.
package wb_spi_pkg;

  typedef enum logic [1:0] {
    StWait,
    StIdle,
    StShift,
    StDone
  } spi_state_e;

  localparam int unsigned SPI_MAX_BITS = 32;
  localparam int unsigned BITCNT_W     = 6;

  // Index of the final bit of a frame of (size + 1) bytes.
  function automatic logic [BITCNT_W-1:0] last_bit_idx(input logic [1:0] size);
    return {1'b0, size, 3'b111};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses taken from the last two stages.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic primed_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] primed_q;

  // Synchronizer chain plus a fill marker: the chain only holds real pin
  // samples once every reset-seeded stage has been overwritten.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= {SYNC_STAGES{rst_val_i}};
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], d_i};
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Pulses fire the cycle before q_o flips, so q_o still shows the old level.
  always_comb begin
    primed_o = primed_q[SYNC_STAGES-1];
    q_o      = sync_q[SYNC_STAGES-1];
    rise_o   = primed_o & sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    fall_o   = primed_o & ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/wb_spi_target.sv
// SPI target (CPHA=0, 8..32-bit MSB-first frames) with a Wishbone TX/RX holding-word port.
module wb_spi_target
  import wb_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        wb_spi_cyc_i,
  input  logic        wb_spi_stb_i,
  input  logic        wb_spi_we_i,
  output logic        wb_spi_ack_o,
  input  logic [31:0] wb_spi_dat_i,
  output logic [31:0] wb_spi_dat_o,
  input  logic [1:0]  size_i,
  input  logic        cpol_i,
  output logic        rx_valid_o,
  output logic        rx_ovr_o,
  output logic        tx_empty_o,
  input  logic        spi_cs_i,
  input  logic        spi_sck_i,
  input  logic        spi_sdi_i,
  output logic        spi_sdo_o,
  output logic        spi_sdo_oe_o
);

  logic cs_s, cs_rise, cs_fall, cs_primed;
  logic sck_s, sck_rise, sck_fall, sck_primed;
  logic sdi_s;
  logic [SYNC_STAGES-1:0] sdi_sync_q;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk_i    (clk_i),
    .rst_ni   (rst_in),
    .rst_val_i(1'b1),
    .d_i      (spi_cs_i),
    .q_o      (cs_s),
    .rise_o   (cs_rise),
    .fall_o   (cs_fall),
    .primed_o (cs_primed)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk_i    (clk_i),
    .rst_ni   (rst_in),
    .rst_val_i(cpol_i),
    .d_i      (spi_sck_i),
    .q_o      (sck_s),
    .rise_o   (sck_rise),
    .fall_o   (sck_fall),
    .primed_o (sck_primed)
  );

  // SDI needs no edge detection, just the synchronizer.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) sdi_sync_q <= '0;
    else         sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_i};
  end
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  spi_state_e              state_q, state_d;
  logic [1:0]              size_q, size_d;
  logic [BITCNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [SPI_MAX_BITS-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic [31:0]             tx_buf_q, tx_buf_d, rx_buf_q, rx_buf_d;
  logic                    tx_empty_q, tx_empty_d, rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic                    wr, rd, lead, trail, done;
  logic [SPI_MAX_BITS-1:0] rx_sh_next;

  // State and data registers.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StWait;
      size_q     <= '0;
      bitcnt_q   <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      tx_buf_q   <= '0;
      rx_buf_q   <= '0;
      tx_empty_q <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      bitcnt_q   <= bitcnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      tx_buf_q   <= tx_buf_d;
      rx_buf_q   <= rx_buf_d;
      tx_empty_q <= tx_empty_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  // Frame FSM, shifters and Wishbone register updates.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    bitcnt_d   = bitcnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    tx_buf_d   = tx_buf_q;
    rx_buf_d   = rx_buf_q;
    tx_empty_d = tx_empty_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    done       = 1'b0;

    wr = wb_spi_cyc_i & wb_spi_stb_i & wb_spi_we_i;
    rd = wb_spi_cyc_i & wb_spi_stb_i & ~wb_spi_we_i;
    // sck_s still holds the pre-edge level while a pulse is active.
    lead       = (sck_rise | sck_fall) & (sck_s == cpol_i);
    trail      = (sck_rise | sck_fall) & (sck_s != cpol_i);
    rx_sh_next = {rx_sh_q[SPI_MAX_BITS-2:0], sdi_s};

    unique case (state_q)
      // A CS held low across reset must be seen high before any frame starts.
      StWait: if (cs_primed & sck_primed & cs_s) state_d = StIdle;
      StIdle: begin
        if (cs_fall) begin
          state_d    = StShift;
          size_d     = size_i;
          bitcnt_d   = '0;
          rx_sh_d    = '0;
          tx_sh_d    = tx_empty_q ? '0 : tx_buf_q;
          tx_empty_d = 1'b1;
        end
      end
      StShift: begin
        if (cs_rise) begin
          state_d = StIdle;
        end else if (lead) begin
          rx_sh_d  = rx_sh_next;
          bitcnt_d = bitcnt_q + BITCNT_W'(1);
          if (bitcnt_q == last_bit_idx(size_q)) begin
            state_d = StDone;
            done    = 1'b1;
          end
        end else if (trail) begin
          tx_sh_d = tx_sh_q << 1;
        end
      end
      StDone:  if (cs_rise) state_d = StIdle;
      default: state_d = StWait;
    endcase

    // A write in the CS-fall cycle stays pending for the next frame.
    if (wr) begin
      tx_buf_d   = wb_spi_dat_i;
      tx_empty_d = 1'b0;
    end

    if (done) begin
      rx_buf_d   = rx_sh_next;
      rx_valid_d = 1'b1;
      rx_ovr_d   = rd ? 1'b0 : (rx_ovr_q | rx_valid_q);
    end else if (rd) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
  end

  // Output decode.
  always_comb begin
    wb_spi_ack_o = wb_spi_cyc_i & wb_spi_stb_i;
    wb_spi_dat_o = rx_buf_q;
    rx_valid_o   = rx_valid_q;
    rx_ovr_o     = rx_ovr_q;
    tx_empty_o   = tx_empty_q;
    spi_sdo_o    = (state_q == StShift) & tx_sh_q[SPI_MAX_BITS-1];
    spi_sdo_oe_o = (state_q != StWait) & ~cs_s;
  end

endmodule

// File: tb/tb_wb_spi_target.sv
// Scoreboard bench for wb_spi_target: stimulus pushes expectations, a monitor compares.
module tb_wb_spi_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic [1:0]  size;
  logic        cpol;
  logic        rx_valid, rx_ovr, tx_empty;
  logic        spi_cs, spi_sck, spi_sdi, spi_sdo, spi_sdo_oe;

  always #5 clk = ~clk;

  wb_spi_target #(.SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rst_in      (rst_n),
    .wb_spi_cyc_i(wb_cyc),
    .wb_spi_stb_i(wb_stb),
    .wb_spi_we_i (wb_we),
    .wb_spi_ack_o(wb_ack),
    .wb_spi_dat_i(wb_dat_i),
    .wb_spi_dat_o(wb_dat_o),
    .size_i      (size),
    .cpol_i      (cpol),
    .rx_valid_o  (rx_valid),
    .rx_ovr_o    (rx_ovr),
    .tx_empty_o  (tx_empty),
    .spi_cs_i    (spi_cs),
    .spi_sck_i   (spi_sck),
    .spi_sdi_i   (spi_sdi),
    .spi_sdo_o   (spi_sdo),
    .spi_sdo_oe_o(spi_sdo_oe)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic        v;
    logic        o;
    logic        t;
  } rd_exp_t;

  typedef struct packed {
    logic v;
    logic o;
    logic t;
    logic oe;
  } st_exp_t;

  rd_exp_t     rd_q[$];
  st_exp_t     st_q[$];
  logic [31:0] host_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic        probe = 1'b0;
  logic        host_valid = 1'b0;
  logic [31:0] host_rx = '0;
  logic [31:0] fall_word = '0;

  rd_exp_t     mon_rd;
  st_exp_t     mon_st;
  logic [31:0] mon_host;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT (or host model) presents a result.
  always @(negedge clk) begin
    if (wb_ack && !wb_we) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        mon_rd = rd_q.pop_front();
        check("rd_dat", wb_dat_o, mon_rd.dat);
        check("rd_valid", {31'd0, rx_valid}, {31'd0, mon_rd.v});
        check("rd_ovr", {31'd0, rx_ovr}, {31'd0, mon_rd.o});
        check("rd_tx_empty", {31'd0, tx_empty}, {31'd0, mon_rd.t});
      end
    end
    if (probe) begin
      if (st_q.size() == 0) begin
        check("st_unexpected", 32'd1, 32'd0);
      end else begin
        mon_st = st_q.pop_front();
        check("st_valid", {31'd0, rx_valid}, {31'd0, mon_st.v});
        check("st_ovr", {31'd0, rx_ovr}, {31'd0, mon_st.o});
        check("st_tx_empty", {31'd0, tx_empty}, {31'd0, mon_st.t});
        check("st_sdo_oe", {31'd0, spi_sdo_oe}, {31'd0, mon_st.oe});
      end
    end
    if (host_valid) begin
      if (host_q.size() == 0) begin
        check("host_unexpected", 32'd1, 32'd0);
      end else begin
        mon_host = host_q.pop_front();
        check("host_rx", host_rx, mon_host);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [31:0] d);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_dat_i = d;
    tick(1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] d, input logic v, input logic o, input logic t);
    rd_q.push_back('{dat: d, v: v, o: o, t: t});
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
    tick(1);
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic check_status(input logic v, input logic o, input logic t, input logic oe);
    st_q.push_back('{v: v, o: o, t: t, oe: oe});
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
  endtask

  // Host frame. mode 0: normal, 1: abort after 5 bits, 2: WB write of fall_word in the
  // CS-fall cycle, 3: WB read issued in the completion cycle (caller pushes its expectation).
  task automatic spi_frame(input int nbits, input logic [31:0] host_tx,
                           input logic [31:0] exp_rx, input int mode);
    logic [31:0] rx;
    int bits;
    rx   = '0;
    bits = (mode == 1) ? 5 : nbits;
    if (mode != 1) host_q.push_back(exp_rx);
    spi_cs = 1'b0;
    if (mode == 2) begin
      tick(1);
      wb_write(fall_word);
    end
    tick(8);
    for (int i = 0; i < bits; i++) begin
      spi_sdi = host_tx[nbits-1-i];
      tick(4);
      rx      = {rx[30:0], spi_sdo};
      spi_sck = ~cpol;
      if (mode == 3 && i == bits - 1) begin
        tick(1);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        tick(1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick(2);
      end else begin
        tick(4);
      end
      spi_sck = cpol;
    end
    tick(4);
    spi_cs  = 1'b1;
    spi_sdi = 1'b0;
    if (mode != 1) begin
      host_rx    = rx;
      host_valid = 1'b1;
      tick(1);
      host_valid = 1'b0;
    end
    tick(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_dat_i = '0;
    size = 2'd0; cpol = 1'b0;
    spi_cs = 1'b1; spi_sck = 1'b0; spi_sdi = 1'b0;
    tick(3);
    check_status(1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick(8);
    wb_read(32'h0, 1'b0, 1'b0, 1'b1);

    // 1: 8-bit, cpol 0
    wb_write(32'hA500_0000);
    check_status(1'b0, 1'b0, 1'b0, 1'b0);
    spi_frame(8, 32'h3C, 32'hA5, 0);
    check_status(1'b1, 1'b0, 1'b1, 1'b0);
    wb_read(32'h0000_003C, 1'b1, 1'b0, 1'b1);
    check_status(1'b0, 1'b0, 1'b1, 1'b0);

    // 2: 32-bit, cpol 1
    cpol = 1'b1; spi_sck = 1'b1; size = 2'd3;
    tick(6);
    wb_write(32'hDEAD_BEEF);
    spi_frame(32, 32'h1234_5678, 32'hDEAD_BEEF, 0);
    wb_read(32'h1234_5678, 1'b1, 1'b0, 1'b1);

    // 3: overrun
    cpol = 1'b0; spi_sck = 1'b0; size = 2'd0;
    tick(6);
    spi_frame(8, 32'h11, 32'h00, 0);
    spi_frame(8, 32'h22, 32'h00, 0);
    check_status(1'b1, 1'b1, 1'b1, 1'b0);
    wb_read(32'h0000_0022, 1'b1, 1'b1, 1'b1);
    check_status(1'b0, 1'b0, 1'b1, 1'b0);

    // 4: empty TX sends zeros; write in CS-fall cycle stays pending
    size = 2'd1;
    spi_frame(16, 32'hBEEF, 32'h0000, 0);
    check_status(1'b1, 1'b0, 1'b1, 1'b0);
    wb_read(32'h0000_BEEF, 1'b1, 1'b0, 1'b1);
    fall_word = 32'hC3C3_0000;
    spi_frame(16, 32'h1234, 32'h0000, 2);
    check_status(1'b1, 1'b0, 1'b0, 1'b0);
    wb_read(32'h0000_1234, 1'b1, 1'b0, 1'b0);
    size = 2'd0;
    spi_frame(8, 32'h5A, 32'hC3, 0);
    check_status(1'b1, 1'b0, 1'b1, 1'b0);
    wb_read(32'h0000_005A, 1'b1, 1'b0, 1'b1);

    // 5: abort leaves RX untouched; next frame intact
    spi_frame(8, 32'h77, 32'h00, 0);
    spi_frame(8, 32'hFF, 32'h00, 1);
    check_status(1'b1, 1'b0, 1'b1, 1'b0);
    wb_read(32'h0000_0077, 1'b1, 1'b0, 1'b1);
    spi_frame(8, 32'h96, 32'h00, 0);
    wb_read(32'h0000_0096, 1'b1, 1'b0, 1'b1);

    // 5b: CS low through reset release, clocks ignored until CS seen high
    spi_cs = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(6);
    for (int i = 0; i < 8; i++) begin
      spi_sdi = 1'b1;
      tick(4);
      spi_sck = 1'b1;
      tick(4);
      spi_sck = 1'b0;
    end
    tick(4);
    check_status(1'b0, 1'b0, 1'b1, 1'b0);
    wb_read(32'h0, 1'b0, 1'b0, 1'b1);
    spi_cs = 1'b1; spi_sdi = 1'b0;
    tick(10);
    spi_frame(8, 32'hE1, 32'h00, 0);
    wb_read(32'h0000_00E1, 1'b1, 1'b0, 1'b1);

    // 6: read in the completion cycle
    spi_frame(8, 32'h44, 32'h00, 0);
    rd_q.push_back('{dat: 32'h0000_0044, v: 1'b1, o: 1'b0, t: 1'b1});
    spi_frame(8, 32'h99, 32'h00, 3);
    check_status(1'b1, 1'b0, 1'b1, 1'b0);
    wb_read(32'h0000_0099, 1'b1, 1'b0, 1'b1);

    tick(4);
    check("rd_q_left", rd_q.size(), 32'd0);
    check("st_q_left", st_q.size(), 32'd0);
    check("host_q_left", host_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
